// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module pipeline_stall_ctrl #(
    parameter int BR_PENALTY  = 1,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_hz,
    input  logic             branch_taken,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic [1:0]       state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam logic [3:0]       PEN_RELOAD = 4'(BR_PENALTY - 1);
    localparam logic [15:0]      WAIT_MAX   = 16'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_e           state_q, state_d, saved_q, saved_d, cur_state;
    logic [3:0]       pen_q, pen_d;
    logic [15:0]      wait_q, wait_d;
    logic             to_q, to_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;

    // Output decode and next-state: a freeze overrides everything; otherwise
    // the state being resumed (saved state on the release cycle) is decoded.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_write  = 1'b1;
        memwb_bubble = 1'b0;
        state_d      = state_q;
        saved_d      = saved_q;
        pen_d        = pen_q;
        wait_d       = wait_q;
        to_d         = to_q;
        stall_d      = stall_q;
        flush_d      = flush_q;
        if (rst) begin
            cur_state = RUN;
        end else if (state_q == MEM_WAIT) begin
            cur_state = saved_q;
        end else begin
            cur_state = state_q;
        end

        if (dmem_busy) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
            if (state_q != MEM_WAIT) begin
                saved_d = state_q;
                state_d = MEM_WAIT;
                wait_d  = 16'd1;
            end else begin
                if (wait_q != WAIT_MAX) begin
                    wait_d = wait_q + 16'd1;
                end
                if (wait_d == WAIT_MAX) begin
                    to_d = 1'b1;
                end
            end
        end else begin
            wait_d  = 16'd0;
            state_d = cur_state;
            case (cur_state)
                RUN: begin
                    if (branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        if (BR_PENALTY > 1) begin
                            state_d = FLUSH;
                            pen_d   = PEN_RELOAD;
                        end
                    end else if (load_use_hz) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        if (stall_q != CNT_MAX) begin
                            stall_d = stall_q + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    ifid_flush = 1'b1;
                    if (branch_taken) begin
                        idex_bubble = 1'b1;
                        pen_d       = PEN_RELOAD;
                    end else if (pen_q <= 4'd1) begin
                        state_d = RUN;
                        pen_d   = 4'd0;
                    end else begin
                        pen_d = pen_q - 4'd1;
                    end
                end
                default: state_d = RUN;
            endcase
            if (ifid_flush && flush_q != CNT_MAX) begin
                flush_d = flush_q + 1'b1;
            end
        end
    end

    // State, counters and sticky watchdog flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            saved_q <= RUN;
            pen_q   <= 4'd0;
            wait_q  <= 16'd0;
            to_q    <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            pen_q   <= pen_d;
            wait_q  <= wait_d;
            to_q    <= to_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign state        = state_q;
    assign mem_timeout  = to_q;
    assign stall_cycles = stall_q;
    assign flush_cycles = flush_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - scoreboard bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

    localparam logic [6:0] N_O = 7'b1101010;
    localparam logic [6:0] S_O = 7'b0001110;
    localparam logic [6:0] B_O = 7'b1111110;
    localparam logic [6:0] F_O = 7'b1111010;
    localparam logic [6:0] Z_O = 7'b0000001;

    typedef struct {
        logic [6:0]  o;
        logic [1:0]  st;
        logic        to;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, load_use_hz, branch_taken, dmem_busy;
    logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
    logic        exmem_write, memwb_bubble, mem_timeout;
    logic [1:0]  state;
    logic [15:0] stall_cycles, flush_cycles;

    int          checks = 0;
    int          errors = 0;
    int          step_no = 0;
    logic        exp_to = 1'b0;
    logic [15:0] exp_stall = '0;
    logic [15:0] exp_flush = '0;
    exp_t        sb[$];

    pipeline_stall_ctrl #(.BR_PENALTY(3), .MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .load_use_hz(load_use_hz), .branch_taken(branch_taken),
        .dmem_busy(dmem_busy), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_write(idex_write), .idex_bubble(idex_bubble),
        .exmem_write(exmem_write), .memwb_bubble(memwb_bubble), .state(state),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", tag, step_no, act, exp);
        end
    endtask

    function automatic logic [6:0] ctrl_vec();
        return {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble};
    endfunction

    task automatic step(input logic lu, input logic br, input logic busy,
                        input logic [6:0] eo, input logic [1:0] es);
        exp_t e;
        @(negedge clk);
        step_no++;
        load_use_hz  = lu;
        branch_taken = br;
        dmem_busy    = busy;
        e.o  = eo;
        e.st = es;
        e.to = exp_to;
        e.sc = exp_stall;
        e.fc = exp_flush;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        check_eq("ctrl", 32'(ctrl_vec()), 32'(e.o));
        check_eq("state", 32'(state), 32'(e.st));
        check_eq("mem_timeout", 32'(mem_timeout), 32'(e.to));
        check_eq("stall_cycles", 32'(stall_cycles), 32'(e.sc));
        check_eq("flush_cycles", 32'(flush_cycles), 32'(e.fc));
        if (eo == S_O) exp_stall++;
        if (eo[4]) exp_flush++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        load_use_hz = 1'b0;
        branch_taken = 1'b0;
        dmem_busy = 1'b0;
        @(negedge clk);
        #1;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_ctrl", 32'(ctrl_vec()), 32'(N_O));
        rst = 1'b0;
        exp_to = 1'b0;
        exp_stall = '0;
        exp_flush = '0;
    endtask

    initial begin
        rst = 1'b1;
        load_use_hz = 1'b0;
        branch_taken = 1'b0;
        dmem_busy = 1'b0;
        do_reset();
        // idle and single load-use stall
        step(0, 0, 0, N_O, 2'd0);
        step(1, 0, 0, S_O, 2'd0);
        step(0, 0, 0, N_O, 2'd0);
        // taken branch: three flush cycles, states 0,1,1,0
        step(0, 1, 0, B_O, 2'd0);
        step(0, 0, 0, F_O, 2'd1);
        step(0, 0, 0, F_O, 2'd1);
        step(0, 0, 0, N_O, 2'd0);
        // branch, then 5-cycle freeze during FLUSH with penalty 2; watchdog trips
        step(0, 1, 0, B_O, 2'd0);
        step(0, 0, 1, Z_O, 2'd1);
        step(0, 0, 1, Z_O, 2'd2);
        step(0, 0, 1, Z_O, 2'd2);
        step(0, 0, 1, Z_O, 2'd2);
        exp_to = 1'b1;
        step(0, 0, 1, Z_O, 2'd2);
        step(0, 0, 0, F_O, 2'd2);
        step(0, 0, 0, F_O, 2'd1);
        step(0, 0, 0, N_O, 2'd0);
        // branch beats load-use; load-use ignored in FLUSH
        step(1, 1, 0, B_O, 2'd0);
        step(0, 0, 0, F_O, 2'd1);
        step(1, 0, 0, F_O, 2'd1);
        step(0, 0, 0, N_O, 2'd0);
        // busy with branch from RUN: freeze, then branch re-presented on release
        step(0, 1, 1, Z_O, 2'd0);
        step(0, 1, 0, B_O, 2'd2);
        step(0, 0, 0, F_O, 2'd1);
        step(0, 0, 0, F_O, 2'd1);
        step(0, 0, 0, N_O, 2'd0);
        // branch re-taken inside FLUSH restarts the penalty
        step(0, 1, 0, B_O, 2'd0);
        step(0, 1, 0, B_O, 2'd1);
        step(0, 0, 0, F_O, 2'd1);
        step(0, 0, 0, F_O, 2'd1);
        step(0, 0, 0, N_O, 2'd0);
        // reset mid-sequence from MEM_WAIT clears everything
        step(0, 1, 0, B_O, 2'd0);
        step(0, 0, 1, Z_O, 2'd1);
        do_reset();
        step(0, 0, 0, N_O, 2'd0);
        step(1, 0, 0, S_O, 2'd0);
        step(0, 0, 0, N_O, 2'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
